// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with architectural Z/C flags and ALU carry-in feedback.
// Optional result forwarding is enabled by defining EXMEM_RESULT_FWD_EN.
module exmem_stage #(
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [7:0]        ex_result,
   input  logic              ex_zero,
   input  logic              ex_carry,
   input  logic [7:0]        ex_store_data,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_we,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_flag_we_z,
   input  logic              ex_flag_we_c,
   input  logic              stall,
   input  logic              flush,
   input  logic [REG_AW-1:0] fwd_rs,
   output logic              mem_valid,
   output logic [7:0]        mem_result,
   output logic [7:0]        mem_store_data,
   output logic [REG_AW-1:0] mem_rd,
   output logic              mem_reg_we,
   output logic              mem_mem_read,
   output logic              mem_mem_write,
   output logic              flag_z,
   output logic              flag_c,
   output logic              alu_carry_in,
   output logic              fwd_hit,
   output logic [7:0]        fwd_data
);

   logic              valid_q, valid_d;
   logic [7:0]        result_q, result_d;
   logic [7:0]        store_data_q, store_data_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              reg_we_q, reg_we_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              flag_z_q, flag_z_d;
   logic              flag_c_q, flag_c_d;
   logic              accept_s;

   assign accept_s = ex_valid & ~stall & ~flush;

   // Next-state for the stage registers: flush squashes, stall holds, else load.
   always_comb begin
      valid_d      = valid_q;
      result_d     = result_q;
      store_data_d = store_data_q;
      rd_d         = rd_q;
      reg_we_d     = reg_we_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      if (flush) begin
         valid_d     = 1'b0;
         reg_we_d    = 1'b0;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
      end else if (stall) begin
         valid_d = valid_q;
      end else begin
         valid_d      = ex_valid;
         result_d     = ex_result;
         store_data_d = ex_store_data;
         rd_d         = ex_rd;
         reg_we_d     = ex_reg_we & ex_valid;
         mem_read_d   = ex_mem_read & ex_valid;
         mem_write_d  = ex_mem_write & ex_valid;
      end
   end

   // Flags change only on an accepted instruction, each under its own enable.
   always_comb begin
      if (accept_s && ex_flag_we_z) begin
         flag_z_d = ex_zero;
      end else begin
         flag_z_d = flag_z_q;
      end
      if (accept_s && ex_flag_we_c) begin
         flag_c_d = ex_carry;
      end else begin
         flag_c_d = flag_c_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         result_q     <= 8'h00;
         store_data_q <= 8'h00;
         rd_q         <= '0;
         reg_we_q     <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         flag_z_q     <= 1'b0;
         flag_c_q     <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         result_q     <= result_d;
         store_data_q <= store_data_d;
         rd_q         <= rd_d;
         reg_we_q     <= reg_we_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         flag_z_q     <= flag_z_d;
         flag_c_q     <= flag_c_d;
      end
   end

   assign mem_valid      = valid_q;
   assign mem_result     = result_q;
   assign mem_store_data = store_data_q;
   assign mem_rd         = rd_q;
   assign mem_reg_we     = reg_we_q;
   assign mem_mem_read   = mem_read_q;
   assign mem_mem_write  = mem_write_q;
   assign flag_z         = flag_z_q;
   assign flag_c         = flag_c_q;
   // Carry-in comes only from the register, never from ex_carry, to avoid an ALU loop.
   assign alu_carry_in   = flag_c_q;

`ifdef EXMEM_RESULT_FWD_EN
   // Loads are excluded: their data only exists after the memory access.
   assign fwd_hit  = valid_q & reg_we_q & ~mem_read_q & (rd_q == fwd_rs);
   assign fwd_data = result_q;
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = 8'h00;
`endif

endmodule

// File: tb/tb_exmem_stage.sv
// Table-driven self-checking bench for exmem_stage plus a multi-cycle stall sequence.
module tb_exmem_stage;

   logic       clk = 1'b0;
   logic       rst, ex_valid, ex_zero, ex_carry;
   logic [7:0] ex_result, ex_store_data;
   logic [2:0] ex_rd, fwd_rs;
   logic       ex_reg_we, ex_mem_read, ex_mem_write, ex_flag_we_z, ex_flag_we_c;
   logic       stall, flush;
   logic       mem_valid, mem_reg_we, mem_mem_read, mem_mem_write;
   logic [7:0] mem_result, mem_store_data, fwd_data;
   logic [2:0] mem_rd;
   logic       flag_z, flag_c, alu_carry_in, fwd_hit;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exmem_stage #(.REG_AW(3)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
      .ex_zero(ex_zero), .ex_carry(ex_carry), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_flag_we_z(ex_flag_we_z),
      .ex_flag_we_c(ex_flag_we_c), .stall(stall), .flush(flush), .fwd_rs(fwd_rs),
      .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
      .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .flag_z(flag_z), .flag_c(flag_c),
      .alu_carry_in(alu_carry_in), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
   );

   typedef struct {
      logic rst, v; logic [7:0] res; logic z, c; logic [7:0] sd; logic [2:0] rd;
      logic we, mr, mw, fwz, fwc, st, fl; logic [2:0] rs;
   } in_t;

   typedef struct {
      logic valid; logic [7:0] res, sd; logic [2:0] rd;
      logic we, mr, mw, fz, fc, hit; logic [7:0] fdata; logic chkd;
   } exp_t;

   typedef struct { in_t i; exp_t e; } vec_t;

   localparam int NV = 17;
   vec_t vec [NV];

   function automatic in_t vin(logic r, logic v, logic [7:0] res, logic z, logic c,
                               logic [7:0] sd, logic [2:0] rd, logic we, logic mr,
                               logic mw, logic fwz, logic fwc, logic st, logic fl,
                               logic [2:0] rs);
      in_t t;
      t = '{r, v, res, z, c, sd, rd, we, mr, mw, fwz, fwc, st, fl, rs};
      return t;
   endfunction

   function automatic exp_t vexp(logic valid, logic [7:0] res, logic [7:0] sd,
                                 logic [2:0] rd, logic we, logic mr, logic mw,
                                 logic fz, logic fc, logic hit, logic [7:0] fdata,
                                 logic chkd);
      exp_t t;
      t = '{valid, res, sd, rd, we, mr, mw, fz, fc, hit, fdata, chkd};
      return t;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input in_t t);
      rst = t.rst; ex_valid = t.v; ex_result = t.res; ex_zero = t.z; ex_carry = t.c;
      ex_store_data = t.sd; ex_rd = t.rd; ex_reg_we = t.we; ex_mem_read = t.mr;
      ex_mem_write = t.mw; ex_flag_we_z = t.fwz; ex_flag_we_c = t.fwc;
      stall = t.st; flush = t.fl; fwd_rs = t.rs;
   endtask

   task automatic check_vec(input int n, input exp_t e);
      logic       ehit;
      logic [7:0] edata;
`ifdef EXMEM_RESULT_FWD_EN
      ehit = e.hit; edata = e.fdata;
`else
      ehit = 1'b0; edata = 8'h00;
`endif
      chk($sformatf("v%0d mem_valid", n), {7'd0, mem_valid}, {7'd0, e.valid});
      chk($sformatf("v%0d mem_reg_we", n), {7'd0, mem_reg_we}, {7'd0, e.we});
      chk($sformatf("v%0d mem_mem_read", n), {7'd0, mem_mem_read}, {7'd0, e.mr});
      chk($sformatf("v%0d mem_mem_write", n), {7'd0, mem_mem_write}, {7'd0, e.mw});
      chk($sformatf("v%0d flag_z", n), {7'd0, flag_z}, {7'd0, e.fz});
      chk($sformatf("v%0d flag_c", n), {7'd0, flag_c}, {7'd0, e.fc});
      chk($sformatf("v%0d alu_carry_in", n), {7'd0, alu_carry_in}, {7'd0, e.fc});
      chk($sformatf("v%0d fwd_hit", n), {7'd0, fwd_hit}, {7'd0, ehit});
      if (e.chkd) begin
         chk($sformatf("v%0d mem_result", n), mem_result, e.res);
         chk($sformatf("v%0d mem_store_data", n), mem_store_data, e.sd);
         chk($sformatf("v%0d mem_rd", n), {5'd0, mem_rd}, {5'd0, e.rd});
         chk($sformatf("v%0d fwd_data", n), fwd_data, edata);
      end
   endtask

   initial begin
      // vin(rst,v,res,z,c,sd,rd,we,mr,mw,fwz,fwc,stall,flush,rs)
      // vexp(valid,res,sd,rd,we,mr,mw,fz,fc,hit,fdata,chkd)
      vec[0]  = '{vin(1,1,8'hFF,1,1,8'hAA,3'd7,1,1,1,1,1,0,0,3'd0), vexp(0,8'h00,8'h00,3'd0,0,0,0,0,0,0,8'h00,1)};
      vec[1]  = '{vin(1,1,8'hFF,1,1,8'hAA,3'd7,1,1,1,1,1,0,0,3'd0), vexp(0,8'h00,8'h00,3'd0,0,0,0,0,0,0,8'h00,1)};
      vec[2]  = '{vin(0,1,8'h00,1,1,8'h11,3'd1,1,0,0,1,1,0,0,3'd1), vexp(1,8'h00,8'h11,3'd1,1,0,0,1,1,1,8'h00,1)};
      vec[3]  = '{vin(0,1,8'h00,1,0,8'h22,3'd2,1,0,0,1,0,0,0,3'd1), vexp(1,8'h00,8'h22,3'd2,1,0,0,1,1,0,8'h00,1)};
      vec[4]  = '{vin(0,1,8'h3C,0,0,8'h33,3'd5,1,1,0,1,1,0,0,3'd5), vexp(1,8'h3C,8'h33,3'd5,1,1,0,0,0,0,8'h3C,1)};
      vec[5]  = '{vin(0,1,8'hA5,1,1,8'h44,3'd6,1,0,0,1,1,1,0,3'd5), vexp(1,8'h3C,8'h33,3'd5,1,1,0,0,0,0,8'h3C,1)};
      vec[6]  = vec[5];
      vec[7]  = vec[5];
      vec[8]  = '{vin(0,1,8'hA5,1,1,8'h44,3'd6,1,0,0,1,1,0,0,3'd6), vexp(1,8'hA5,8'h44,3'd6,1,0,0,1,1,1,8'hA5,1)};
      vec[9]  = '{vin(0,1,8'h40,0,0,8'h99,3'd6,0,0,1,1,1,1,1,3'd6), vexp(0,8'h00,8'h00,3'd0,0,0,0,1,1,0,8'h00,0)};
      vec[10] = '{vin(0,0,8'h55,0,0,8'h66,3'd3,1,0,1,1,1,0,0,3'd3), vexp(0,8'h55,8'h66,3'd3,0,0,0,1,1,0,8'h55,1)};
      vec[11] = '{vin(0,1,8'h80,0,0,8'hC3,3'd4,0,0,1,0,0,0,0,3'd4), vexp(1,8'h80,8'hC3,3'd4,0,0,1,1,1,0,8'h80,1)};
      vec[12] = '{vin(0,1,8'h12,0,0,8'h00,3'd1,1,0,0,1,1,0,1,3'd1), vexp(0,8'h00,8'h00,3'd0,0,0,0,1,1,0,8'h00,0)};
      vec[13] = '{vin(0,1,8'h7E,0,0,8'h00,3'd2,1,0,0,1,1,0,0,3'd2), vexp(1,8'h7E,8'h00,3'd2,1,0,0,0,0,1,8'h7E,1)};
      vec[14] = '{vin(0,1,8'h7E,0,0,8'h00,3'd2,1,1,0,1,1,0,0,3'd2), vexp(1,8'h7E,8'h00,3'd2,1,1,0,0,0,0,8'h7E,1)};
      vec[15] = '{vin(1,1,8'h7E,1,1,8'h00,3'd2,1,0,1,1,1,1,1,3'd2), vexp(0,8'h00,8'h00,3'd0,0,0,0,0,0,0,8'h00,1)};
      vec[16] = '{vin(0,1,8'h01,0,1,8'h02,3'd7,1,0,0,1,1,0,0,3'd7), vexp(1,8'h01,8'h02,3'd7,1,0,0,0,1,1,8'h01,1)};

      for (int n = 0; n < NV; n++) begin
         @(negedge clk);
         drive(vec[n].i);
         @(posedge clk);
         #1;
         check_vec(n, vec[n].e);
      end

      // Long stall: EX presents a new flag-writing op, nothing may move.
      @(negedge clk);
      drive(vin(0,1,8'hE7,1,0,8'h5A,3'd3,1,0,1,1,1,1,0,3'd7));
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d mem_result", k), mem_result, 8'h01);
         chk($sformatf("stall%0d flag_z", k), {7'd0, flag_z}, 8'h00);
         chk($sformatf("stall%0d alu_carry_in", k), {7'd0, alu_carry_in}, 8'h01);
         chk($sformatf("stall%0d mem_mem_write", k), {7'd0, mem_mem_write}, 8'h00);
      end
      @(negedge clk);
      stall = 1'b0;
      @(posedge clk);
      #1;
      chk("release mem_result", mem_result, 8'hE7);
      chk("release mem_store_data", mem_store_data, 8'h5A);
      chk("release mem_mem_write", {7'd0, mem_mem_write}, 8'h01);
      chk("release flag_z", {7'd0, flag_z}, 8'h01);
      chk("release flag_c", {7'd0, flag_c}, 8'h00);
      chk("release alu_carry_in", {7'd0, alu_carry_in}, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
